// File: rtl/i2s_tx_pkg.sv
// Shared audio definitions: sample format, I2S framing constants and transmitter states.
package i2s_tx_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int I2S_SLOTS    = 2 * SAMPLE_W_DEF;

    typedef logic signed [SAMPLE_W_DEF-1:0] sample_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    function automatic int slot_count(input int sample_w);
        return 2 * sample_w;
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// Sample-source and I2S line signals of the transmitter; master is the transmitter side.
interface i2s_tx_if
    import i2s_tx_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) ();

    logic                enable_i;
    logic [SAMPLE_W-1:0] left_i;
    logic [SAMPLE_W-1:0] right_i;
    logic                sample_req_o;
    logic                bclk_o;
    logic                lrclk_o;
    logic                sdata_o;

    modport master (
        input  enable_i, left_i, right_i,
        output sample_req_o, bclk_o, lrclk_o, sdata_o
    );

    modport slave (
        output enable_i, left_i, right_i,
        input  sample_req_o, bclk_o, lrclk_o, sdata_o
    );

endinterface

// File: rtl/i2s_tx_clkgen.sv
// Bit-clock generator: divides clk into bclk, counts slots, drives word select and flags bclk falls.
module i2s_tx_clkgen
    import i2s_tx_pkg::*;
#(
    parameter int BCLK_DIV = 4,
    parameter int SLOTS    = I2S_SLOTS
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic run_i,
    output logic bclk_o,
    output logic lrclk_o,
    output logic fall_o,
    output logic wrap_o
);

    localparam int              CW        = $clog2(SLOTS);
    localparam logic [7:0]      DIV_LAST  = 8'(BCLK_DIV - 1);
    localparam logic [CW-1:0]   SLOT_LAST = CW'(SLOTS - 1);
    localparam logic [CW-1:0]   SLOT_HALF = CW'(SLOTS / 2);

    logic [7:0]    div_cnt_q, div_cnt_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          bclk_q, bclk_d;
    logic          lrclk_q, lrclk_d;
    logic          toggle;

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        toggle    = (div_cnt_q == DIV_LAST);
        div_cnt_d = toggle ? 8'd0 : div_cnt_q + 8'd1;
        bclk_d    = bclk_q ^ toggle;
        fall_o    = toggle & bclk_q;
        wrap_o    = fall_o & (bit_cnt_q == SLOT_LAST);
        bit_cnt_d = bit_cnt_q;
        if (fall_o) begin
            bit_cnt_d = wrap_o ? '0 : bit_cnt_q + CW'(1);
        end
        lrclk_d   = (bit_cnt_d >= SLOT_HALF);
        if (!run_i) begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            fall_o    = 1'b0;
            wrap_o    = 1'b0;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
        end
    end

    assign bclk_o  = bclk_q;
    assign lrclk_o = lrclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: captures a stereo sample per frame and serialises it MSB first with one-bclk delay.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int BCLK_DIV = 4,
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input logic      clk,
    input logic      rst_ni,
    i2s_tx_if.master bus
);

    localparam int SLOTS = slot_count(SAMPLE_W);

    tx_state_e        state_q, state_d;
    logic [SLOTS-1:0] frame_q, frame_d;
    logic             sdata_q, sdata_d;
    logic             req_q, req_d;
    logic             run, fall, wrap, load;

    assign run = (state_q == ST_RUN) & bus.enable_i;

    i2s_tx_clkgen #(
        .BCLK_DIV (BCLK_DIV),
        .SLOTS    (SLOTS)
    ) u_clkgen (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .run_i   (run),
        .bclk_o  (bus.bclk_o),
        .lrclk_o (bus.lrclk_o),
        .fall_o  (fall),
        .wrap_o  (wrap)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            ST_IDLE: if (bus.enable_i) begin
                state_d = ST_RUN;
                load    = 1'b1;
            end
            ST_RUN: begin
                if (bus.enable_i) load = wrap;
                else              state_d = ST_IDLE;
            end
        endcase

        frame_d = frame_q;
        sdata_d = sdata_q;
        req_d   = load;
        // The outgoing MSB is taken before a load overwrites the frame, so the old right LSB leads the new frame.
        if (!bus.enable_i) begin
            frame_d = '0;
            sdata_d = 1'b0;
        end else if (load || fall) begin
            sdata_d = frame_q[SLOTS-1];
            frame_d = load ? {bus.left_i, bus.right_i} : frame_q << 1;
        end
    end

    // NOTE: the frame register is reset like the counters because its MSB feeds sdata_o directly.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            frame_q <= '0;
            sdata_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            sdata_q <= sdata_d;
            req_q   <= req_d;
        end
    end

    assign bus.sdata_o      = sdata_q;
    assign bus.sample_req_o = req_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at BCLK_DIV=2 and BCLK_DIV=1 with a per-slot scoreboard of expected bits.
module tb_i2s_tx;

    typedef struct packed {
        logic sd;
        logic lr;
    } slot_t;

    logic clk = 1'b0;
    logic rst_ni;

    always #5 clk = ~clk;

    i2s_tx_if #(.SAMPLE_W(16)) bus2 ();
    i2s_tx_if #(.SAMPLE_W(16)) bus1 ();

    i2s_tx #(.BCLK_DIV(2), .SAMPLE_W(16)) dut2 (.clk(clk), .rst_ni(rst_ni), .bus(bus2));
    i2s_tx #(.BCLK_DIV(1), .SAMPLE_W(16)) dut1 (.clk(clk), .rst_ni(rst_ni), .bus(bus1));

    slot_t exp2[$];
    slot_t exp1[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    rises2   = 0;
    int    rises1   = 0;
    int    last2    = -1;
    int    last1    = -1;
    logic  prev2    = 1'b0;
    logic  prev1    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected slots for one frame: slot 0 carries the previous right LSB, then {left,right} MSB first.
    task automatic push_frame(input int which, input logic r0, input logic [15:0] l, input logic [15:0] r);
        logic [31:0] f;
        slot_t       s;
        f = {l, r};
        for (int k = 0; k < 32; k++) begin
            if (k == 0) s.sd = r0;
            else        s.sd = f[32-k];
            s.lr = (k >= 16);
            if (which == 1) exp1.push_back(s);
            else            exp2.push_back(s);
        end
    endtask

    task automatic tick();
        slot_t s;
        @(negedge clk);
        cyc++;
        if (bus2.bclk_o && !prev2) begin
            rises2++;
            check("dut2_sb_pending", 32'(exp2.size() != 0), 1);
            if (exp2.size() != 0) begin
                s = exp2.pop_front();
                check($sformatf("dut2_sdata_rise%0d", rises2), 32'(bus2.sdata_o), 32'(s.sd));
                check($sformatf("dut2_lrclk_rise%0d", rises2), 32'(bus2.lrclk_o), 32'(s.lr));
            end
        end
        prev2 = bus2.bclk_o;
        if (bus2.sample_req_o) begin
            if (last2 >= 0) check("dut2_req_period", cyc - last2, 128);
            last2 = cyc;
        end
        if (bus1.bclk_o && !prev1) begin
            rises1++;
            check("dut1_sb_pending", 32'(exp1.size() != 0), 1);
            if (exp1.size() != 0) begin
                s = exp1.pop_front();
                check($sformatf("dut1_sdata_rise%0d", rises1), 32'(bus1.sdata_o), 32'(s.sd));
                check($sformatf("dut1_lrclk_rise%0d", rises1), 32'(bus1.lrclk_o), 32'(s.lr));
            end
        end
        prev1 = bus1.bclk_o;
        if (bus1.sample_req_o) begin
            if (last1 >= 0) check("dut1_req_period", cyc - last1, 64);
            last1 = cyc;
        end
    endtask

    task automatic run_rises(input int which, input int n);
        int target;
        int budget;
        target = ((which == 1) ? rises1 : rises2) + n;
        budget = n * 8 + 16;
        while (((which == 1) ? rises1 : rises2) < target && budget > 0) begin
            tick();
            budget--;
        end
        check("rise_budget", 32'(((which == 1) ? rises1 : rises2) >= target), 1);
    endtask

    task automatic check_quiet2(input string tag);
        check({tag, "_bclk"},  32'(bus2.bclk_o),       0);
        check({tag, "_lrclk"}, 32'(bus2.lrclk_o),      0);
        check({tag, "_sdata"}, 32'(bus2.sdata_o),      0);
        check({tag, "_req"},   32'(bus2.sample_req_o), 0);
    endtask

    initial begin
        rst_ni        = 1'b0;
        bus2.enable_i = 1'b0;
        bus2.left_i   = '0;
        bus2.right_i  = '0;
        bus1.enable_i = 1'b0;
        bus1.left_i   = '0;
        bus1.right_i  = '0;

        #12;
        check_quiet2("reset");
        check("reset_dut1_bclk",  32'(bus1.bclk_o),  0);
        check("reset_dut1_sdata", 32'(bus1.sdata_o), 0);
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        check_quiet2("idle");

        // Steady frames with A5C3/0F0F, then mid-frame input changes that must wait for the next load.
        bus2.left_i   = 16'hA5C3;
        bus2.right_i  = 16'h0F0F;
        bus2.enable_i = 1'b1;
        push_frame(2, 1'b0, 16'hA5C3, 16'h0F0F);
        push_frame(2, 1'b1, 16'hA5C3, 16'h0F0F);
        tick();
        check("start_req",  32'(bus2.sample_req_o), 1);
        check("start_bclk", 32'(bus2.bclk_o),       0);
        tick();
        check("start_req_single", 32'(bus2.sample_req_o), 0);
        run_rises(2, 40);
        bus2.left_i  = 16'h1234;
        bus2.right_i = 16'h5A5A;
        push_frame(2, 1'b1, 16'h1234, 16'h5A5A);
        run_rises(2, 34);
        bus2.left_i = 16'hFFFF;
        push_frame(2, 1'b0, 16'hFFFF, 16'h5A5A);
        run_rises(2, 32);

        // Abort at slot 9, then restart from idle.
        bus2.enable_i = 1'b0;
        last2         = -1;
        tick();
        check_quiet2("abort");
        check("abort_pending", exp2.size(), 22);
        exp2.delete();
        tick();
        tick();
        bus2.left_i   = 16'h6B1E;
        bus2.right_i  = 16'hC3A7;
        bus2.enable_i = 1'b1;
        push_frame(2, 1'b0, 16'h6B1E, 16'hC3A7);
        tick();
        check("reen_req",   32'(bus2.sample_req_o), 1);
        check("reen_bclk0", 32'(bus2.bclk_o),       0);
        tick();
        check("reen_bclk1", 32'(bus2.bclk_o),       0);
        tick();
        check("reen_bclk2", 32'(bus2.bclk_o),       1);
        run_rises(2, 20);

        // Asynchronous reset at slot 20 while enabled.
        check("pre_rst_lrclk", 32'(bus2.lrclk_o), 1);
        rst_ni = 1'b0;
        #1;
        check_quiet2("async_rst");
        exp2.delete();
        last2 = -1;
        prev2 = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        push_frame(2, 1'b0, 16'h6B1E, 16'hC3A7);
        push_frame(2, 1'b1, 16'h6B1E, 16'hC3A7);
        tick();
        check("post_rst_req",  32'(bus2.sample_req_o), 1);
        check("post_rst_bclk", 32'(bus2.bclk_o),       0);
        run_rises(2, 33);
        check("post_rst_pending", exp2.size(), 31);
        bus2.enable_i = 1'b0;
        last2         = -1;
        tick();
        exp2.delete();

        // Fastest divider: bclk toggles every clk, 64-clk frames.
        bus1.left_i   = 16'h8000;
        bus1.right_i  = 16'h0001;
        bus1.enable_i = 1'b1;
        push_frame(1, 1'b0, 16'h8000, 16'h0001);
        push_frame(1, 1'b1, 16'h8000, 16'h0001);
        tick();
        check("div1_req",   32'(bus1.sample_req_o), 1);
        check("div1_bclk0", 32'(bus1.bclk_o),       0);
        tick();
        check("div1_bclk1", 32'(bus1.bclk_o),       1);
        tick();
        check("div1_bclk2", 32'(bus1.bclk_o),       0);
        tick();
        check("div1_bclk3", 32'(bus1.bclk_o),       1);
        run_rises(1, 31);
        check("div1_pending", exp1.size(), 31);
        check("div1_dut2_idle", 32'(bus2.bclk_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
